// File: rtl/pl_pkg.sv
// Shared bundle layout for the elastic pipeline stage registers (ID/EXE, EXE/MEM, MEM/WB).
// Every stage packs and unpacks its control and data bundles through these offsets and helpers.
package pl_pkg;

  localparam int PL_CTRL_W = 10;
  localparam int PL_DATA_W = 133;

  // Control bundle bit offsets (LSB first).
  localparam int CTRL_JAL    = 0;
  localparam int CTRL_SHIFT  = 1;
  localparam int CTRL_ALUIMM = 2;
  localparam int CTRL_ALUC   = 3;
  localparam int CTRL_ALUC_W = 4;
  localparam int CTRL_WMEM   = 7;
  localparam int CTRL_M2REG  = 8;
  localparam int CTRL_WREG   = 9;

  // Data bundle bit offsets (LSB first).
  localparam int WORD_W    = 32;
  localparam int RN_W      = 5;
  localparam int DATA_RN   = 0;
  localparam int DATA_PC4  = 5;
  localparam int DATA_IMM  = 37;
  localparam int DATA_B    = 69;
  localparam int DATA_A    = 101;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [3:0] aluc;
    logic       aluimm;
    logic       shift;
    logic       jal;
  } ctrl_t;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] imm;
    logic [WORD_W-1:0] pc4;
    logic [RN_W-1:0]   rn;
  } data_t;

  function automatic logic [PL_CTRL_W-1:0] pack_ctrl(input ctrl_t c);
    return PL_CTRL_W'(c);
  endfunction

  function automatic ctrl_t unpack_ctrl(input logic [PL_CTRL_W-1:0] v);
    return ctrl_t'(v);
  endfunction

  function automatic logic [PL_DATA_W-1:0] pack_data(input data_t d);
    return PL_DATA_W'(d);
  endfunction

  function automatic data_t unpack_data(input logic [PL_DATA_W-1:0] v);
    return data_t'(v);
  endfunction

  // True when a control word could change architectural state.
  function automatic logic has_side_effect(input logic [PL_CTRL_W-1:0] v);
    return v[CTRL_WREG] | v[CTRL_WMEM];
  endfunction

endpackage

// File: rtl/pl_entry.sv
// One valid-plus-payload register. Clear beats load; the payload only changes on a load,
// so a cleared entry keeps presenting its last value.
module pl_entry #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/pl_stage_reg.sv
// Elastic valid/ready pipeline stage carrying a control and a data bundle, with flush,
// forced-zero control on bubbles and an optional skid entry that registers in_ready.
module pl_stage_reg
  import pl_pkg::*;
#(
  parameter int CTRL_W = PL_CTRL_W,
  parameter int DATA_W = PL_DATA_W,
  parameter int SKID   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam int ENT_W = CTRL_W + DATA_W;

  logic             main_valid, skid_valid;
  logic [ENT_W-1:0] main_q, skid_q, main_d;
  logic             main_load, main_clear, main_from_skid;
  logic             skid_load, skid_clear;
  logic             accept, drain;

  assign accept = in_valid & in_ready;
  assign drain  = main_valid & out_ready;

  // Steering: the main entry is always the oldest; the skid entry only fills while main stalls.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (skid_valid) begin
      if (drain) begin
        main_load      = 1'b1;
        main_from_skid = 1'b1;
        skid_clear     = 1'b1;
      end
    end else if (accept) begin
      if (!main_valid || out_ready) begin
        main_load = 1'b1;
      end else begin
        skid_load = 1'b1;
      end
    end else if (drain) begin
      main_clear = 1'b1;
    end
  end

  assign main_d = main_from_skid ? skid_q : {in_ctrl, in_data};

  pl_entry #(.W(ENT_W)) u_main (
    .clock (clock),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pl_entry #(.W(ENT_W)) u_skid (
        .clock (clock),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     ({in_ctrl, in_data}),
        .valid (skid_valid),
        .q     (skid_q)
      );
      assign in_ready = !skid_valid;
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_q     = '0;
      // While reset is held the stage simply mirrors downstream readiness.
      assign in_ready   = reset ? out_ready : (!main_valid | out_ready);
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_q[ENT_W-1:DATA_W] : '0;
  assign out_data  = main_q[DATA_W-1:0];
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pl_stage_reg.sv
// Bench for pl_stage_reg: one SKID=1 and one SKID=0 instance share stimulus; a queue model
// of the stage (capacity and FIFO order) predicts every output.
module tb_pl_stage_reg;

  localparam int CW = 10;
  localparam int DW = 133;
  localparam int EW = CW + DW;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          flush;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          ir1, ov1, ir0, ov0;
  logic [CW-1:0] oc1, oc0;
  logic [DW-1:0] od1, od0;
  logic [1:0]    occ1, occ0;

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] q1[$];
  logic [EW-1:0] q0[$];
  logic [DW-1:0] last1, last0;

  always #5 clock = ~clock;

  pl_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(ov1),
    .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1), .occupancy(occ1)
  );

  pl_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(ov0),
    .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0), .occupancy(occ0)
  );

  // ---------------- reference model ----------------
  function automatic logic m_ready(input int k);
    if (k == 1) return reset ? 1'b1 : (q1.size() < 2);
    return reset ? out_ready : (q0.size() == 0 || out_ready);
  endfunction

  function automatic int m_occ(input int k);
    return (k == 1) ? q1.size() : q0.size();
  endfunction

  function automatic logic m_valid(input int k);
    return m_occ(k) > 0;
  endfunction

  function automatic logic [CW-1:0] m_ctrl(input int k);
    if (k == 1) return (q1.size() > 0) ? q1[0][EW-1:DW] : '0;
    return (q0.size() > 0) ? q0[0][EW-1:DW] : '0;
  endfunction

  function automatic logic [DW-1:0] m_data(input int k);
    if (k == 1) return (q1.size() > 0) ? q1[0][DW-1:0] : last1;
    return (q0.size() > 0) ? q0[0][DW-1:0] : last0;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 5; i++) d = {d[DW-33:0], 32'($urandom)};
    return d;
  endfunction

  // Advance one clock edge and apply the stage rules to both model queues.
  task automatic tick();
    logic r1, r0;
    r1 = m_ready(1);
    r0 = m_ready(0);
    @(posedge clock);
    if (reset) begin
      q1.delete(); q0.delete();
      last1 = '0; last0 = '0;
    end else if (flush) begin
      q1.delete(); q0.delete();
    end else begin
      if (q1.size() > 0 && out_ready) void'(q1.pop_front());
      if (q0.size() > 0 && out_ready) void'(q0.pop_front());
      if (in_valid && r1) q1.push_back({in_ctrl, in_data});
      if (in_valid && r0) q0.push_back({in_ctrl, in_data});
    end
    if (q1.size() > 0) last1 = q1[0][DW-1:0];
    if (q0.size() > 0) last0 = q0[0][DW-1:0];
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DW-1:0] d;
    d = rand_data();
    reset = 1'b1; in_valid = 1'b1; in_ctrl = '1; in_data = d;
    flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    tests++; if (ov1 !== 1'b0 || oc1 !== '0 || od1 !== '0 || occ1 !== 2'd0) begin
      fails++; $display("FAIL reset_skid1 v=%b ctrl=%h data=%h occ=%0d expected all zero", ov1, oc1, od1, occ1);
    end
    tests++; if (ov0 !== 1'b0 || oc0 !== '0 || od0 !== '0 || occ0 !== 2'd0) begin
      fails++; $display("FAIL reset_skid0 v=%b ctrl=%h data=%h occ=%0d expected all zero", ov0, oc0, od0, occ0);
    end
    tests++; if (ir1 !== 1'b1) begin fails++; $display("FAIL reset_in_ready1 got %b expected 1", ir1); end
    tests++; if (ir0 !== 1'b0) begin fails++; $display("FAIL reset_in_ready0_low got %b expected 0", ir0); end
    out_ready = 1'b1; #1;
    tests++; if (ir0 !== 1'b1) begin fails++; $display("FAIL reset_in_ready0_high got %b expected 1", ir0); end
    reset = 1'b0;
    tick();
    tests++; if (ov1 !== 1'b1 || oc1 !== 10'h3FF || od1 !== d) begin
      fails++; $display("FAIL first_after_reset1 v=%b ctrl=%h data=%h expected 1 3ff %h", ov1, oc1, od1, d);
    end
    tests++; if (ov0 !== 1'b1 || oc0 !== 10'h3FF || od0 !== d) begin
      fails++; $display("FAIL first_after_reset0 v=%b ctrl=%h data=%h expected 1 3ff %h", ov0, oc0, od0, d);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_ctrl = CW'(i); in_data = DW'(i);
      tick();
      tests++; if (ov1 !== 1'b1 || od1 !== DW'(i) || occ1 !== 2'd1 || ir1 !== 1'b1) begin
        fails++; $display("FAIL stream1[%0d] v=%b data=%0d occ=%0d rdy=%b expected 1 %0d 1 1", i, ov1, od1, occ1, ir1, i);
      end
      tests++; if (ov0 !== 1'b1 || od0 !== DW'(i) || occ0 !== 2'd1 || ir0 !== 1'b1) begin
        fails++; $display("FAIL stream0[%0d] v=%b data=%0d occ=%0d rdy=%b expected 1 %0d 1 1", i, ov0, od0, occ0, ir0, i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_skid_stall();
    logic [DW-1:0] a, b, c;
    a = rand_data(); b = rand_data(); c = rand_data();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 10'h011;
    in_data = a; tick();
    tests++; if (occ1 !== 2'd1 || ir1 !== 1'b1 || od1 !== a) begin
      fails++; $display("FAIL stall_a occ=%0d rdy=%b data=%h expected 1 1 %h", occ1, ir1, od1, a);
    end
    in_data = b; tick();
    tests++; if (occ1 !== 2'd2 || ir1 !== 1'b0 || od1 !== a) begin
      fails++; $display("FAIL stall_b occ=%0d rdy=%b data=%h expected 2 0 %h", occ1, ir1, od1, a);
    end
    in_data = c; tick();
    tests++; if (occ1 !== 2'd2 || ir1 !== 1'b0 || od1 !== a || ov1 !== 1'b1) begin
      fails++; $display("FAIL stall_c occ=%0d rdy=%b data=%h v=%b expected 2 0 %h 1", occ1, ir1, od1, ov1, a);
    end
    out_ready = 1'b1; tick();
    tests++; if (od1 !== b || occ1 !== 2'd1 || ir1 !== 1'b1) begin
      fails++; $display("FAIL drain_b data=%h occ=%0d rdy=%b expected %h 1 1", od1, occ1, ir1, b);
    end
    tick();
    tests++; if (od1 !== c || occ1 !== 2'd1 || ov1 !== 1'b1) begin
      fails++; $display("FAIL drain_c data=%h occ=%0d v=%b expected %h 1 1", od1, occ1, ov1, c);
    end
    in_valid = 1'b0; tick();
    tests++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin
      fails++; $display("FAIL drain_empty v=%b occ=%0d expected 0 0", ov1, occ1);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 10'h3FF;
    in_data = rand_data(); tick();
    in_data = rand_data(); tick();
    in_data = rand_data(); flush = 1'b1; tick();
    tests++; if (ov1 !== 1'b0 || oc1 !== '0 || occ1 !== 2'd0) begin
      fails++; $display("FAIL flush1 v=%b ctrl=%h occ=%0d expected 0 0 0", ov1, oc1, occ1);
    end
    tests++; if (ov0 !== 1'b0 || oc0 !== '0 || occ0 !== 2'd0) begin
      fails++; $display("FAIL flush0 v=%b ctrl=%h occ=%0d expected 0 0 0", ov0, oc0, occ0);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (ov1 !== 1'b0 || ov0 !== 1'b0 || od1 !== m_data(1)) begin
        fails++; $display("FAIL flush_after[%0d] v1=%b v0=%b data1=%h expected 0 0 %h", i, ov1, ov0, od1, m_data(1));
      end
    end
  endtask

  task automatic test_bubble();
    logic [DW-1:0] d1, d3;
    d1 = rand_data(); d3 = rand_data();
    out_ready = 1'b1; in_ctrl = 10'h3FF;
    in_valid = 1'b1; in_data = d1; tick();
    tests++; if (oc1 !== 10'h3FF || od1 !== d1 || oc0 !== 10'h3FF || od0 !== d1) begin
      fails++; $display("FAIL bubble_first ctrl1=%h ctrl0=%h data1=%h expected 3ff %h", oc1, oc0, od1, d1);
    end
    in_valid = 1'b0; in_data = rand_data(); tick();
    tests++; if (oc1 !== '0 || ov1 !== 1'b0 || od1 !== d1 || oc0 !== '0 || od0 !== d1) begin
      fails++; $display("FAIL bubble_gap ctrl1=%h ctrl0=%h data1=%h data0=%h expected 0 0 %h", oc1, oc0, od1, od0, d1);
    end
    in_valid = 1'b1; in_data = d3; tick();
    tests++; if (oc1 !== 10'h3FF || od1 !== d3 || oc0 !== 10'h3FF || od0 !== d3) begin
      fails++; $display("FAIL bubble_third ctrl1=%h ctrl0=%h data1=%h expected 3ff %h", oc1, oc0, od1, d3);
    end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_skid0_backpressure();
    logic [DW-1:0] x, y;
    x = rand_data(); y = rand_data();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 10'h155; in_data = x; tick();
    out_ready = 1'b0; in_data = y; #1;
    tests++; if (ir0 !== 1'b0) begin fails++; $display("FAIL bp_in_ready0 got %b expected 0", ir0); end
    tick();
    tests++; if (ov0 !== 1'b1 || od0 !== x || occ0 !== 2'd1) begin
      fails++; $display("FAIL bp_hold_x v=%b data=%h occ=%0d expected 1 %h 1", ov0, od0, occ0, x);
    end
    out_ready = 1'b1; tick();
    tests++; if (ov0 !== 1'b1 || od0 !== y || occ0 !== 2'd1) begin
      fails++; $display("FAIL bp_next_y v=%b data=%h occ=%0d expected 1 %h 1", ov0, od0, occ0, y);
    end
    in_valid = 1'b0; tick();
    tests++; if (ov0 !== 1'b0 || occ0 !== 2'd0) begin
      fails++; $display("FAIL bp_empty v=%b occ=%0d expected 0 0", ov0, occ0);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 10'h2A5;
    in_data = rand_data(); tick();
    in_data = rand_data(); tick();
    #2 reset = 1'b1; #1;
    tests++; if (ov1 !== 1'b0 || oc1 !== '0 || od1 !== '0 || occ1 !== 2'd0 || ov0 !== 1'b0 || occ0 !== 2'd0) begin
      fails++; $display("FAIL midreset v1=%b ctrl1=%h occ1=%0d v0=%b occ0=%0d expected all zero", ov1, oc1, occ1, ov0, occ0);
    end
    tick();
    reset = 1'b0; out_ready = 1'b1; in_data = rand_data(); tick();
    tests++; if (ov1 !== 1'b1 || od1 !== in_data || occ1 !== 2'd1 || ov0 !== 1'b1 || od0 !== in_data) begin
      fails++; $display("FAIL midreset_first v1=%b data1=%h occ1=%0d v0=%b expected 1 %h 1 1", ov1, od1, occ1, ov0, in_data);
    end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_ctrl   = CW'($urandom);
      in_data   = rand_data();
      #1;
      tests++; if (ir1 !== m_ready(1) || ov1 !== m_valid(1) || oc1 !== m_ctrl(1) ||
                   od1 !== m_data(1) || occ1 !== 2'(m_occ(1))) begin
        fails++; $display("FAIL rand1[%0d] rdy=%b v=%b ctrl=%h occ=%0d data=%h expected %b %b %h %0d %h",
                          n, ir1, ov1, oc1, occ1, od1, m_ready(1), m_valid(1), m_ctrl(1), m_occ(1), m_data(1));
      end
      tests++; if (ir0 !== m_ready(0) || ov0 !== m_valid(0) || oc0 !== m_ctrl(0) ||
                   od0 !== m_data(0) || occ0 !== 2'(m_occ(0))) begin
        fails++; $display("FAIL rand0[%0d] rdy=%b v=%b ctrl=%h occ=%0d data=%h expected %b %b %h %0d %h",
                          n, ir0, ov0, oc0, occ0, od0, m_ready(0), m_valid(0), m_ctrl(0), m_occ(0), m_data(0));
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    last1 = '0; last0 = '0;
    test_reset();
    test_stream();
    test_skid_stall();
    test_flush();
    test_bubble();
    test_skid0_backpressure();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pl_stage_reg.md
Name: pl_stage_reg

Overview:
- Parametrised elastic pipeline stage register. Successor to the fixed ID/EXE latch.
- Carries a control bundle and a data bundle between two pipeline stages using a valid/ready handshake.
- Adds stall (backpressure), flush (kill), bubble insertion with forced-zero control, and an optional skid entry for full throughput under registered ready.
- Instantiated between ID and EXE, and reusable between EXE/MEM and MEM/WB.

Parameters:
- CTRL_W, 10: control bundle width (wreg, m2reg, wmem, aluc[3:0], aluimm, shift, jal). Forced to zero whenever the stage holds no valid entry.
- DATA_W, 133: data bundle width (a, b, imm, pc4, rn). Never forced; holds last value.
- SKID, 1: 0 = single entry with combinational ready path; 1 = main plus skid entry with registered in_ready.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- flush  in  1  kill all held entries and the current input (branch/jump redirect)
- out_valid  out  1  downstream entry present
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control to next stage; 0 when out_valid=0
- out_data  out  DATA_W  data to next stage
- occupancy  out  2  entries held (0..1 when SKID=0, 0..2 when SKID=1)

Behaviour:
- Reset (async, active-high):
  - all entries invalid; out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=1 when SKID=1; in_ready=out_ready when SKID=0.
- Accept = in_valid & in_ready at a rising edge. Drain = out_valid & out_ready at a rising edge.
- Latency: an accepted entry appears on out_* the next cycle. Order is strictly FIFO.
- SKID=0:
  - one entry register; in_ready = !valid | out_ready (combinational).
  - On accept, the entry loads; on drain without accept, valid clears.
  - Full throughput of 1 per cycle is sustained while out_ready=1.
- SKID=1: main (output) entry and skid entry; in_ready = !skid_valid (registered).
  - Accept into an empty stage, or while draining a lone main entry: loads main.
  - Accept while main is valid and not draining: loads skid.
  - Drain while skid is valid: skid moves to main; a new accept in the same cycle is impossible (in_ready=0).
  - occupancy = main_valid + skid_valid.
- Stall (out_ready=0): all held entries, out_ctrl and out_data are stable. No entry is lost or duplicated.
- Flush, synchronous at the edge:
  - all entries invalid and any input handshaked that cycle discarded.
  - Next cycle: out_valid=0, out_ctrl=0, occupancy=0.
  - Flush wins over simultaneous accept and drain. A drain in the flush cycle still counts as delivered to downstream.
- Bubble rule: whenever out_valid=0, out_ctrl=0. This guarantees no register write and no memory write from a bubble. out_data keeps its last value.
- in_ctrl and in_data are sampled only on accept; values on non-accept cycles are ignored.
- Reset mid-stream: immediate clear regardless of clock. The first accept after reset release behaves as into an empty stage.
- out_valid never drops without a drain or flush, and out_data never changes while out_valid=1 and out_ready=0 (valid/ready stability rule).

Decomposition:
- Shared package pl_pkg:
  - CTRL_W and DATA_W constants.
  - field offset constants for wreg, m2reg, wmem, aluc, aluimm, shift, jal, a, b, imm, pc4 and rn, so stages pack and unpack bundles identically.
- One natural sub-module, pl_entry: a single valid-plus-payload register with load, clear and async reset. It is instantiated once (SKID=0) or twice (SKID=1). Handshake and steering logic stays in pl_stage_reg.

Test Plan:
- Reset with in_valid=1 and in_ctrl=10'h3FF held → out_valid=0, out_ctrl=0, out_data=0, occupancy=0 while reset=1; first entry appears one cycle after release.
- Stream of 8 entries (data = 1..8) with out_ready=1 → out_data = 1..8 on consecutive cycles, one-cycle latency, in_ready stays 1, occupancy=1.
- SKID=1, out_ready=0 for 3 cycles while feeding A, B, C:
  - A is held in main and B in skid; in_ready=0 from cycle 2; occupancy=2; C is not accepted.
  - After out_ready=1, the outputs are A, B, C in order.
- Flush with main=A, skid=B, in_valid=1 (C) → next cycle out_valid=0, out_ctrl=0, occupancy=0; A, B and C are never output.
- Bubble check: in_ctrl=10'h3FF with in_valid toggling 1,0,1 → out_ctrl = 3FF, 000, 3FF; out_data holds its value during the bubble.
- SKID=0 backpressure: out_ready low for 1 cycle with entry X held → in_ready=0 that cycle; X stays stable; the next entry follows X with no loss or duplication.
